// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage and the data memory.
// One request outstanding at a time; MEM_ACK/MEM_RDATA come back from the slave.
interface mem_access_if;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_STRB;
    logic [31:0] MEM_WDATA;
    logic        MEM_ACK;
    logic [31:0] MEM_RDATA;

    modport master (
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA,
        input  MEM_ACK, MEM_RDATA
    );

    modport slave (
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_STRB, MEM_WDATA,
        output MEM_ACK, MEM_RDATA
    );
endinterface

// File: rtl/mem_access.sv
// Pipeline memory-access stage: passes ALU results through, runs one blocking
// load/store on the data bus, formats load data and flags illegal/misaligned ops.
//
// state | meaning
// IDLE  | pass-through; a legal aligned load/store stalls and launches the bus op
// BUSY  | MEM_REQ held with stable bus outputs until MEM_ACK
// RESP  | result presented on A_* for one cycle, stall released
module mem_access (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_INST,
    input  logic        E_VALID,
    input  logic [4:0]  E_REG_D,
    input  logic [31:0] E_REG_D_V,
    input  logic        E_LOAD,
    input  logic        E_STORE,
    input  logic [31:0] E_ADDR,
    input  logic [2:0]  E_FUNCT3,
    input  logic [31:0] E_STORE_DATA,
    output logic [31:0] A_PC,
    output logic [31:0] A_INST,
    output logic        A_VALID,
    output logic [4:0]  A_REG_D,
    output logic [31:0] A_REG_D_V,
    output logic        STALL,
    output logic        MISALIGN,
    mem_access_if.master mem
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  strb_q;
    logic        we_q, load_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        is_ls, legal, aligned, mem_op, bad_op, take_op;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Decode of the execute-side request
    always_comb begin
        is_ls = E_LOAD | E_STORE;
        if (E_LOAD)
            legal = (E_FUNCT3 == 3'b000) || (E_FUNCT3 == 3'b001) || (E_FUNCT3 == 3'b010) ||
                    (E_FUNCT3 == 3'b100) || (E_FUNCT3 == 3'b101);
        else
            legal = (E_FUNCT3 == 3'b000) || (E_FUNCT3 == 3'b001) || (E_FUNCT3 == 3'b010);
        case (E_FUNCT3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~E_ADDR[0];
            2'b10:   aligned = (E_ADDR[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        mem_op = E_VALID & is_ls & legal & aligned;
        bad_op = E_VALID & is_ls & ~(legal & aligned);
    end

    always_comb begin
        case (E_FUNCT3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << E_ADDR[1:0];
                st_wdata = {4{E_STORE_DATA[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << {E_ADDR[1], 1'b0};
                st_wdata = {2{E_STORE_DATA[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = E_STORE_DATA;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        STALL    = 1'b0;
        A_VALID  = 1'b0;
        MISALIGN = 1'b0;
        take_op  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    STALL   = 1'b1;
                    take_op = 1'b1;
                    state_d = BUSY;
                end else if (bad_op) begin
                    MISALIGN = 1'b1;
                end else begin
                    A_VALID = E_VALID;
                end
            end
            BUSY: begin
                STALL = 1'b1;
                if (mem.MEM_ACK) state_d = RESP;
            end
            RESP: begin
                A_VALID = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (RST) begin
            STALL    = 1'b0;
            A_VALID  = 1'b0;
            MISALIGN = 1'b0;
            take_op  = 1'b0;
            state_d  = IDLE;
        end
    end

    // Bus request and response capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            load_q  <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            if (take_op) begin
                addr_q  <= {E_ADDR[31:2], 2'b00};
                we_q    <= ~E_LOAD;
                strb_q  <= E_LOAD ? 4'b0000 : st_strb;
                wdata_q <= E_LOAD ? 32'h0 : st_wdata;
                load_q  <= E_LOAD;
                f3_q    <= E_FUNCT3;
                off_q   <= E_ADDR[1:0];
            end
            if (state_q == BUSY && mem.MEM_ACK)
                rdata_q <= mem.MEM_RDATA;
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    assign A_PC      = E_PC;
    assign A_INST    = E_INST;
    assign A_REG_D   = E_REG_D;
    assign A_REG_D_V = (state_q == RESP && load_q) ? ld_data : E_REG_D_V;

    assign mem.MEM_REQ   = (state_q == BUSY);
    assign mem.MEM_WE    = (state_q == BUSY) & we_q;
    assign mem.MEM_STRB  = (state_q == BUSY) ? strb_q : 4'b0000;
    assign mem.MEM_ADDR  = addr_q;
    assign mem.MEM_WDATA = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads/stores with varying ACK
// latency, illegal/misaligned ops, reset abort and back-to-back transactions.
module tb_mem_access;
    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] E_PC, E_INST, E_REG_D_V, E_ADDR, E_STORE_DATA;
    logic        E_VALID, E_LOAD, E_STORE;
    logic [4:0]  E_REG_D;
    logic [2:0]  E_FUNCT3;
    logic [31:0] A_PC, A_INST, A_REG_D_V;
    logic        A_VALID, STALL, MISALIGN;
    logic [4:0]  A_REG_D;

    int tests = 0;
    int fails = 0;

    mem_access_if bus ();

    mem_access dut (
        .CLK(CLK), .RST(RST),
        .E_PC(E_PC), .E_INST(E_INST), .E_VALID(E_VALID), .E_REG_D(E_REG_D),
        .E_REG_D_V(E_REG_D_V), .E_LOAD(E_LOAD), .E_STORE(E_STORE), .E_ADDR(E_ADDR),
        .E_FUNCT3(E_FUNCT3), .E_STORE_DATA(E_STORE_DATA),
        .A_PC(A_PC), .A_INST(A_INST), .A_VALID(A_VALID), .A_REG_D(A_REG_D),
        .A_REG_D_V(A_REG_D_V), .STALL(STALL), .MISALIGN(MISALIGN),
        .mem(bus)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdv);
        E_VALID = v; E_LOAD = ld; E_STORE = st; E_FUNCT3 = f3;
        E_ADDR = addr; E_STORE_DATA = sdata; E_REG_D_V = rdv;
        E_PC = addr + 32'h100; E_INST = 32'h0000_0013; E_REG_D = 5'd7;
    endtask

    // Runs one transaction from the IDLE cycle (inputs already driven) to RESP
    task automatic do_op(input int ack_at, input logic [31:0] rdata,
                         output int stall_cnt, output int req_cnt,
                         output logic [31:0] b_addr, output logic [3:0] b_strb,
                         output logic [31:0] b_wdata, output logic b_we, output logic stable,
                         output logic r_valid, output logic [31:0] r_val, output logic done);
        stall_cnt = 0; req_cnt = 0; stable = 1'b1; done = 1'b0; r_valid = 1'b0; r_val = '0;
        b_addr = '0; b_strb = '0; b_wdata = '0; b_we = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (!STALL) begin
                done = 1'b1; r_valid = A_VALID; r_val = A_REG_D_V;
            end else begin
                stall_cnt++;
                bus.MEM_ACK = 1'b0;
                if (bus.MEM_REQ) begin
                    req_cnt++;
                    if (req_cnt == 1) begin
                        b_addr = bus.MEM_ADDR; b_strb = bus.MEM_STRB;
                        b_wdata = bus.MEM_WDATA; b_we = bus.MEM_WE;
                    end else if (b_addr !== bus.MEM_ADDR || b_strb !== bus.MEM_STRB ||
                                 b_wdata !== bus.MEM_WDATA || b_we !== bus.MEM_WE) begin
                        stable = 1'b0;
                    end
                    if (req_cnt == ack_at) begin
                        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = rdata;
                    end
                end
                @(negedge CLK);
            end
        end
        bus.MEM_ACK = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h99);
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        tests++; if (STALL !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b exp 0", STALL); end
        tests++; if (A_VALID !== 1'b0) begin fails++; $display("FAIL reset_avalid: got %0b exp 0", A_VALID); end
        tests++; if (bus.MEM_REQ !== 1'b0 || bus.MEM_WE !== 1'b0 || bus.MEM_STRB !== 4'h0)
            begin fails++; $display("FAIL reset_bus_ctl: got req=%0b we=%0b strb=%h exp 0/0/0", bus.MEM_REQ, bus.MEM_WE, bus.MEM_STRB); end
        tests++; if (bus.MEM_ADDR !== 32'h0 || bus.MEM_WDATA !== 32'h0)
            begin fails++; $display("FAIL reset_bus_data: got addr=%h wdata=%h exp 0/0", bus.MEM_ADDR, bus.MEM_WDATA); end
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h1, 32'h0, 32'h0);
        #1;
        tests++; if (MISALIGN !== 1'b0) begin fails++; $display("FAIL reset_misalign: got %0b exp 0", MISALIGN); end
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_alu();
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1234);
        E_REG_D = 5'd5;
        #1;
        tests++; if (A_VALID !== 1'b1) begin fails++; $display("FAIL alu_avalid: got %0b exp 1", A_VALID); end
        tests++; if (A_REG_D_V !== 32'h1234 || A_REG_D !== 5'd5)
            begin fails++; $display("FAIL alu_data: got %h rd=%0d exp 00001234 rd=5", A_REG_D_V, A_REG_D); end
        tests++; if (STALL !== 1'b0 || bus.MEM_REQ !== 1'b0)
            begin fails++; $display("FAIL alu_stall_req: got stall=%0b req=%0b exp 0/0", STALL, bus.MEM_REQ); end
        E_VALID = 1'b0; E_LOAD = 1'b1; E_FUNCT3 = 3'b010;
        @(negedge CLK); #1;
        tests++; if (A_VALID !== 1'b0 || STALL !== 1'b0 || MISALIGN !== 1'b0 || bus.MEM_REQ !== 1'b0)
            begin fails++; $display("FAIL invalid_ignored: got v=%0b s=%0b m=%0b r=%0b exp 0/0/0/0", A_VALID, STALL, MISALIGN, bus.MEM_REQ); end
    endtask

    task automatic check_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input int ack_at, input logic [31:0] rdata, input int exp_stall,
                              input logic [31:0] exp_addr, input logic [31:0] exp_val);
        int sc, rc; logic [31:0] ba, bw, rv; logic [3:0] bs; logic we, st, valid, done;
        @(negedge CLK);
        drive(1'b1, 1'b1, 1'b0, f3, addr, 32'h0, 32'hAAAA_5555);
        do_op(ack_at, rdata, sc, rc, ba, bs, bw, we, st, valid, rv, done);
        tests++; if (!done) begin fails++; $display("FAIL %s_timeout: no RESP within budget", name); end
        tests++; if (sc != exp_stall) begin fails++; $display("FAIL %s_stall_cycles: got %0d exp %0d", name, sc, exp_stall); end
        tests++; if (ba !== exp_addr || bs !== 4'h0 || we !== 1'b0 || !st)
            begin fails++; $display("FAIL %s_bus: got addr=%h strb=%h we=%0b stable=%0b exp %h/0/0/1", name, ba, bs, we, st, exp_addr); end
        tests++; if (valid !== 1'b1 || rv !== exp_val)
            begin fails++; $display("FAIL %s_result: got v=%0b data=%h exp 1/%h", name, valid, rv, exp_val); end
    endtask

    task automatic test_loads();
        check_load("lb",  3'b000, 32'h1003, 2, 32'h80FF_FFFF, 3, 32'h1000, 32'hFFFF_FF80);
        check_load("lbu", 3'b100, 32'h1003, 2, 32'h80FF_FFFF, 3, 32'h1000, 32'h0000_0080);
        check_load("lh",  3'b001, 32'h2002, 1, 32'h8001_1234, 2, 32'h2000, 32'hFFFF_8001);
        check_load("lhu", 3'b101, 32'h2002, 4, 32'h8001_1234, 5, 32'h2000, 32'h0000_8001);
        check_load("lb1", 3'b000, 32'h0501, 1, 32'h1122_7F44, 2, 32'h0500, 32'h0000_007F);
    endtask

    task automatic check_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] sdata, input logic [31:0] exp_addr,
                               input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        int sc, rc; logic [31:0] ba, bw, rv; logic [3:0] bs; logic we, st, valid, done;
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b1, f3, addr, sdata, 32'h0000_0055);
        do_op(1, 32'hFFFF_FFFF, sc, rc, ba, bs, bw, we, st, valid, rv, done);
        tests++; if (!done || sc != 2 || rc != 1)
            begin fails++; $display("FAIL %s_timing: got done=%0b stall=%0d req=%0d exp 1/2/1", name, done, sc, rc); end
        tests++; if (ba !== exp_addr || bs !== exp_strb || bw !== exp_wdata || we !== 1'b1)
            begin fails++; $display("FAIL %s_bus: got addr=%h strb=%h wdata=%h we=%0b exp %h/%h/%h/1", name, ba, bs, bw, we, exp_addr, exp_strb, exp_wdata); end
        tests++; if (valid !== 1'b1 || rv !== 32'h55)
            begin fails++; $display("FAIL %s_result: got v=%0b data=%h exp 1/00000055", name, valid, rv); end
    endtask

    task automatic test_stores();
        check_store("sh", 3'b001, 32'h2002, 32'hDEAD_BEEF, 32'h2000, 4'b1100, 32'hBEEF_BEEF);
        check_store("sb", 3'b000, 32'h0003, 32'h1234_56AB, 32'h0000, 4'b1000, 32'hABAB_ABAB);
        check_store("sw", 3'b010, 32'h0014, 32'h1122_3344, 32'h0014, 4'b1111, 32'h1122_3344);
    endtask

    task automatic check_bad(input string name, input logic ld, input logic [2:0] f3, input logic [31:0] addr);
        int reqs;
        @(negedge CLK);
        drive(1'b1, ld, ~ld, f3, addr, 32'h0, 32'h0);
        #1;
        tests++; if (MISALIGN !== 1'b1 || A_VALID !== 1'b0 || STALL !== 1'b0)
            begin fails++; $display("FAIL %s_flags: got m=%0b v=%0b s=%0b exp 1/0/0", name, MISALIGN, A_VALID, STALL); end
        reqs = 0;
        repeat (3) begin
            @(negedge CLK); #1;
            if (bus.MEM_REQ) reqs++;
        end
        tests++; if (reqs != 0 || MISALIGN !== 1'b1)
            begin fails++; $display("FAIL %s_no_req: got req_cycles=%0d m=%0b exp 0/1", name, reqs, MISALIGN); end
    endtask

    task automatic test_misalign();
        check_bad("lw_3001", 1'b1, 3'b010, 32'h3001);
        check_bad("lh_odd",  1'b1, 3'b001, 32'h0101);
        check_bad("ld_f3_3", 1'b1, 3'b011, 32'h0000);
        check_bad("st_f3_4", 1'b0, 3'b100, 32'h0000);
    endtask

    task automatic test_reset_busy();
        @(negedge CLK);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0040, 32'h0, 32'h0);
        @(negedge CLK); #1;
        tests++; if (bus.MEM_REQ !== 1'b1) begin fails++; $display("FAIL rstbusy_req_before: got %0b exp 1", bus.MEM_REQ); end
        RST = 1'b1;
        @(negedge CLK); #1;
        tests++; if (bus.MEM_REQ !== 1'b0 || STALL !== 1'b0 || A_VALID !== 1'b0)
            begin fails++; $display("FAIL rstbusy_abort: got req=%0b s=%0b v=%0b exp 0/0/0", bus.MEM_REQ, STALL, A_VALID); end
        RST = 1'b0; E_VALID = 1'b0;
        bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h1357_9BDF;
        @(negedge CLK); #1;
        bus.MEM_ACK = 1'b0;
        tests++; if (bus.MEM_REQ !== 1'b0 || A_VALID !== 1'b0 || STALL !== 1'b0)
            begin fails++; $display("FAIL rstbusy_late_ack: got req=%0b v=%0b s=%0b exp 0/0/0", bus.MEM_REQ, A_VALID, STALL); end
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0077);
        #1;
        tests++; if (A_VALID !== 1'b1 || A_REG_D_V !== 32'h77 || STALL !== 1'b0)
            begin fails++; $display("FAIL rstbusy_next_alu: got v=%0b data=%h s=%0b exp 1/00000077/0", A_VALID, A_REG_D_V, STALL); end
    endtask

    task automatic test_back_to_back();
        int sc, rc; logic [31:0] ba, bw, rv; logic [3:0] bs; logic we, st, valid, done;
        int t0, t1;
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        bus.MEM_ACK = 1'b1;
        @(negedge CLK); #1;
        tests++; if (bus.MEM_REQ !== 1'b0 || STALL !== 1'b0)
            begin fails++; $display("FAIL idle_ack_ignored: got req=%0b s=%0b exp 0/0", bus.MEM_REQ, STALL); end
        bus.MEM_ACK = 1'b0;
        @(negedge CLK);
        t0 = $time;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0010, 32'h0, 32'h0);
        do_op(1, 32'hCAFE_F00D, sc, rc, ba, bs, bw, we, st, valid, rv, done);
        tests++; if (!done || sc != 2 || rc != 1 || !st || ba !== 32'h10 || we !== 1'b0)
            begin fails++; $display("FAIL b2b_lw_bus: got done=%0b stall=%0d req=%0d stable=%0b addr=%h we=%0b exp 1/2/1/1/10/0", done, sc, rc, st, ba, we); end
        tests++; if (valid !== 1'b1 || rv !== 32'hCAFE_F00D)
            begin fails++; $display("FAIL b2b_lw_result: got v=%0b data=%h exp 1/cafef00d", valid, rv); end
        @(negedge CLK);
        t1 = $time;
        tests++; if (t1 - t0 != 30) begin fails++; $display("FAIL b2b_lw_latency: got %0d ns exp 30", t1 - t0); end
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0014, 32'h5566_7788, 32'h0000_0042);
        do_op(1, 32'h0, sc, rc, ba, bs, bw, we, st, valid, rv, done);
        tests++; if (!done || sc != 2 || rc != 1 || !st)
            begin fails++; $display("FAIL b2b_sw_timing: got done=%0b stall=%0d req=%0d stable=%0b exp 1/2/1/1", done, sc, rc, st); end
        tests++; if (ba !== 32'h14 || bs !== 4'hF || bw !== 32'h5566_7788 || we !== 1'b1)
            begin fails++; $display("FAIL b2b_sw_bus: got addr=%h strb=%h wdata=%h we=%0b exp 14/f/55667788/1", ba, bs, bw, we); end
        tests++; if (valid !== 1'b1 || rv !== 32'h42)
            begin fails++; $display("FAIL b2b_sw_result: got v=%0b data=%h exp 1/00000042", valid, rv); end
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        #1;
        tests++; if (bus.MEM_REQ !== 1'b0 || bus.MEM_WE !== 1'b0 || bus.MEM_STRB !== 4'h0)
            begin fails++; $display("FAIL b2b_after_idle: got req=%0b we=%0b strb=%h exp 0/0/0", bus.MEM_REQ, bus.MEM_WE, bus.MEM_STRB); end
    endtask

    initial begin
        bus.MEM_ACK = 1'b0;
        bus.MEM_RDATA = '0;
        test_reset();
        test_alu();
        test_loads();
        test_stores();
        test_misalign();
        test_reset_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: CLK  in  1  clock; RST  in  1  reset; one clock, reset synchronous and active-high.
REQ-002 SHALL have execute-side inputs: E_PC in 32; E_INST in 32; E_VALID in 1; E_REG_D in 5; E_REG_D_V in 32 (ALU result); E_LOAD in 1; E_STORE in 1; E_ADDR in 32; E_FUNCT3 in 3; E_STORE_DATA in 32.
REQ-003 SHALL have writeback-register-side outputs: A_PC out 32; A_INST out 32; A_VALID out 1; A_REG_D out 5; A_REG_D_V out 32; STALL out 1 (freezes upstream stages and the following pipeline register); MISALIGN out 1.
REQ-004 SHALL have data-bus ports: MEM_REQ out 1; MEM_WE out 1; MEM_ADDR out 32 (word-aligned, [1:0]=0); MEM_STRB out 4; MEM_WDATA out 32; MEM_ACK in 1; MEM_RDATA in 32.

Function
REQ-005 SHALL implement FSM states IDLE, BUSY, RESP; "mem op" = E_VALID & (E_LOAD | E_STORE) & legal & aligned.
REQ-006 SHALL treat as legal: load funct3 000/001/010/100/101, store funct3 000/001/010; aligned: byte any addr, half addr[0]=0, word addr[1:0]=0.
REQ-007 SHALL in IDLE with E_VALID and no load/store: STALL=0, A_* = E_* pass-through, no bus activity, stay IDLE.
REQ-008 SHALL in IDLE on mem op: STALL=1 same cycle (combinational), register MEM_ADDR/MEM_WE/MEM_STRB/MEM_WDATA, go BUSY.
REQ-009 SHALL in BUSY: MEM_REQ=1, bus outputs stable, STALL=1; on MEM_ACK=1 latch MEM_RDATA, drop MEM_REQ next cycle, go RESP.
REQ-010 SHALL in RESP: STALL=0, A_VALID=1, A_PC/A_INST/A_REG_D from E_* (held by stall); A_REG_D_V = formatted load data for loads, E_REG_D_V for stores; next state IDLE.
REQ-011 SHALL format load data: byte lane = addr[1:0], half lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-012 SHALL generate store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; MEM_WDATA = byte/half replicated across all lanes.
REQ-013 SHALL on illegal or misaligned load/store with E_VALID=1: no bus request, STALL=0, A_VALID=0, MISALIGN=1 for that cycle, stay IDLE.
REQ-014 SHALL keep one transaction outstanding at most; MEM_ACK seen in IDLE or RESP SHALL be ignored.
REQ-015 SHALL accept MEM_ACK in the first BUSY cycle (minimum load/store latency 3 cycles IDLE->BUSY->RESP) and wait indefinitely otherwise (no timeout).
REQ-016 SHALL hold MEM_REQ=0, MEM_WE=0, MEM_STRB=0 outside BUSY.
REQ-017 SHALL ignore E_VALID=0 inputs: A_VALID=0, STALL=0, MISALIGN=0 in IDLE.

Reset
REQ-018 SHALL on RST=1 at a clock edge: state IDLE; MEM_REQ, MEM_WE, MEM_STRB, MEM_ADDR, MEM_WDATA, latched rdata all 0.
REQ-019 SHALL while RST=1 drive STALL=0, A_VALID=0, MISALIGN=0.
REQ-020 SHALL on RST during BUSY abandon the transaction: MEM_REQ=0 from next cycle, no A_VALID for the aborted instruction, late MEM_ACK ignored.

Verification
REQ-021 ALU op E_VALID=1, E_REG_D=5, E_REG_D_V=0x1234 -> same cycle A_VALID=1, A_REG_D_V=0x1234, STALL=0, MEM_REQ=0.
REQ-022 LB addr 0x1003, ACK after 2 BUSY cycles, RDATA=0x80FF_FFFF -> STALL high 3 cycles, MEM_ADDR=0x1000, MEM_STRB=0, RESP A_REG_D_V=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-023 SH addr 0x2002, data 0xDEAD_BEEF, immediate ACK -> MEM_WE=1, MEM_STRB=4'b1100, MEM_WDATA=0xBEEF_BEEF, RESP A_VALID=1.
REQ-024 LW addr 0x3001 -> MISALIGN=1, A_VALID=0, STALL=0, MEM_REQ never asserted.
REQ-025 LW in BUSY, RST pulsed one cycle, ACK arrives after -> MEM_REQ=0 after reset, no A_VALID, state IDLE; next ALU op passes normally.
REQ-026 Back-to-back LW 0x10, SW 0x14 with ACK every first BUSY cycle -> each takes 3 cycles, bus outputs stable while MEM_REQ=1, exactly one ACK consumed per op.
